// File: rtl/intr_pkg.sv
// rtl/intr_pkg.sv - shared constants and types for the interrupt/timer controller
package intr_pkg;

    localparam logic [13:0] CSR_ECFG  = 14'h004;
    localparam logic [13:0] CSR_ESTAT = 14'h005;
    localparam logic [13:0] CSR_TCFG  = 14'h041;
    localparam logic [13:0] CSR_TVAL  = 14'h042;
    localparam logic [13:0] CSR_TICLR = 14'h044;

    localparam int IS_SWI0 = 0;
    localparam int IS_HWI0 = 2;
    localparam int IS_TI   = 11;
    localparam int IS_IPI  = 12;

    localparam logic [12:0] LIE_MASK = 13'h1BFF;

    typedef enum logic [1:0] {
        T_IDLE,
        T_RUN,
        T_DONE
    } timer_state_t;

endpackage

// File: rtl/intr_timer.sv
// rtl/intr_timer.sv - TCFG/TVAL down-counter with one-cycle expiry pulse
module intr_timer
    import intr_pkg::*;
#(
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               tcfg_we,
    input  logic [TIMER_W-1:0] tcfg_new,
    output logic [TIMER_W-1:0] tcfg,
    output logic [TIMER_W-1:0] tval,
    output logic               expire
);

    timer_state_t       state;
    logic [TIMER_W-1:0] reload;
    logic [TIMER_W-1:0] reload_new;

    assign reload     = {tcfg[TIMER_W-1:2], 2'b00};
    assign reload_new = {tcfg_new[TIMER_W-1:2], 2'b00};

    // A TCFG write in the same cycle rearms the counter and suppresses the expiry.
    assign expire = (state == T_RUN) && (tval == '0) && !tcfg_we;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= T_IDLE;
            tcfg  <= '0;
            tval  <= '0;
        end else if (tcfg_we) begin
            tcfg  <= tcfg_new;
            tval  <= reload_new;
            state <= tcfg_new[0] ? T_RUN : T_IDLE;
        end else if (state == T_RUN) begin
            if (tval == '0) begin
                if (tcfg[1]) begin
                    tval <= reload;
                end else begin
                    state <= T_DONE;
                end
            end else begin
                tval <= tval - TIMER_W'(1);
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - ECFG/ESTAT/TCFG/TVAL/TICLR owner and interrupt request generation
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int HW_INT_NUM = 8,
    parameter int TIMER_W    = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [HW_INT_NUM-1:0] hw_int_in,
    input  logic                  ipi_int_in,
    input  logic                  crmd_ie,
    input  logic [13:0]           csr_num,
    input  logic                  csr_we,
    input  logic [31:0]           csr_wmask,
    input  logic [31:0]           csr_wvalue,
    output logic                  intr_hit,
    output logic [31:0]           intr_rvalue,
    output logic                  has_int,
    output logic                  timer_irq
);

    logic [12:0]           lie;
    logic [1:0]            swi;
    logic                  ti;
    logic [HW_INT_NUM-1:0] hw_s1, hw_s2;
    logic                  ipi_s1, ipi_s2;
    logic [12:0]           is_vec;
    logic [TIMER_W-1:0]    tcfg, tval, tcfg_new;
    logic                  expire, tcfg_we, ticlr_clr;

    assign tcfg_we   = csr_we && (csr_num == CSR_TCFG);
    assign ticlr_clr = csr_we && (csr_num == CSR_TICLR) && csr_wvalue[0] && csr_wmask[0];
    assign tcfg_new  = (tcfg & ~csr_wmask[TIMER_W-1:0]) | (csr_wvalue[TIMER_W-1:0] & csr_wmask[TIMER_W-1:0]);

    intr_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk      (clk),
        .resetn   (resetn),
        .tcfg_we  (tcfg_we),
        .tcfg_new (tcfg_new),
        .tcfg     (tcfg),
        .tval     (tval),
        .expire   (expire)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lie    <= '0;
            swi    <= '0;
            ti     <= 1'b0;
            hw_s1  <= '0;
            hw_s2  <= '0;
            ipi_s1 <= 1'b0;
            ipi_s2 <= 1'b0;
        end else begin
            hw_s1  <= hw_int_in;
            hw_s2  <= hw_s1;
            ipi_s1 <= ipi_int_in;
            ipi_s2 <= ipi_s1;
            if (csr_we && (csr_num == CSR_ECFG)) begin
                lie <= ((lie & ~csr_wmask[12:0]) | (csr_wvalue[12:0] & csr_wmask[12:0])) & LIE_MASK;
            end
            if (csr_we && (csr_num == CSR_ESTAT)) begin
                swi <= (swi & ~csr_wmask[1:0]) | (csr_wvalue[1:0] & csr_wmask[1:0]);
            end
            // Expiry beats a simultaneous TICLR clear.
            if (expire) begin
                ti <= 1'b1;
            end else if (ticlr_clr) begin
                ti <= 1'b0;
            end
        end
    end

    always_comb begin
        is_vec                          = '0;
        is_vec[IS_SWI0 +: 2]            = swi;
        is_vec[IS_HWI0 +: HW_INT_NUM]   = hw_s2;
        is_vec[IS_TI]                   = ti;
        is_vec[IS_IPI]                  = ipi_s2;
    end

    always_comb begin
        intr_hit    = 1'b1;
        intr_rvalue = '0;
        case (csr_num)
            CSR_ECFG:  intr_rvalue = 32'(lie);
            CSR_ESTAT: intr_rvalue = 32'(is_vec);
            CSR_TCFG:  intr_rvalue = 32'(tcfg);
            CSR_TVAL:  intr_rvalue = 32'(tval);
            CSR_TICLR: intr_rvalue = '0;
            default:   intr_hit    = 1'b0;
        endcase
    end

    assign has_int   = crmd_ie & |(is_vec & lie);
    assign timer_irq = ti;

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - directed plus randomized checks of intr_ctrl against a behavioural model
module tb_intr_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [7:0]  hw_int_in = '0;
    logic        ipi_int_in = 1'b0;
    logic        crmd_ie = 1'b0;
    logic [13:0] csr_num = '0;
    logic        csr_we = 1'b0;
    logic [31:0] csr_wmask = '0;
    logic [31:0] csr_wvalue = '0;
    logic        intr_hit;
    logic [31:0] intr_rvalue;
    logic        has_int;
    logic        timer_irq;

    intr_ctrl #(.HW_INT_NUM(8), .TIMER_W(32)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .hw_int_in   (hw_int_in),
        .ipi_int_in  (ipi_int_in),
        .crmd_ie     (crmd_ie),
        .csr_num     (csr_num),
        .csr_we      (csr_we),
        .csr_wmask   (csr_wmask),
        .csr_wvalue  (csr_wvalue),
        .intr_hit    (intr_hit),
        .intr_rvalue (intr_rvalue),
        .has_int     (has_int),
        .timer_irq   (timer_irq)
    );

    always #10 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Behavioural model: timer is described by the edge it was armed at, not by a counter.
    logic [12:0] m_lie;
    logic [1:0]  m_swi;
    logic        m_ti;
    logic [31:0] m_tcfg;
    longint      m_edge = 0;
    longint      m_arm  = 0;
    logic [7:0]  hw_seen[$];
    logic        ipi_seen[$];

    task automatic model_reset();
        m_lie  = '0;
        m_swi  = '0;
        m_ti   = 1'b0;
        m_tcfg = '0;
        m_arm  = m_edge;
        hw_seen.delete();
        ipi_seen.delete();
    endtask

    function automatic longint m_init();
        return longint'({m_tcfg[31:2], 2'b00});
    endfunction

    function automatic logic [31:0] m_tval();
        longint d, p;
        d = m_edge - m_arm;
        p = m_init() + 1;
        if (!m_tcfg[0]) return 32'(m_init());
        if (m_tcfg[1]) return 32'(m_init() - (d % p));
        return (d >= m_init()) ? 32'h0 : 32'(m_init() - d);
    endfunction

    function automatic logic [12:0] m_is();
        logic [7:0] h;
        logic       ip;
        h  = (hw_seen.size() >= 2) ? hw_seen[hw_seen.size()-2] : 8'h0;
        ip = (ipi_seen.size() >= 2) ? ipi_seen[ipi_seen.size()-2] : 1'b0;
        return {ip, m_ti, 1'b0, h, m_swi};
    endfunction

    function automatic logic m_hit(input logic [13:0] a);
        return (a == 14'h4) || (a == 14'h5) || (a == 14'h41) || (a == 14'h42) || (a == 14'h44);
    endfunction

    function automatic logic [31:0] m_read(input logic [13:0] a);
        case (a)
            14'h4:   return {19'b0, m_lie};
            14'h5:   return {19'b0, m_is()};
            14'h41:  return m_tcfg;
            14'h42:  return m_tval();
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_has_int();
        return crmd_ie & |(m_is() & m_lie);
    endfunction

    task automatic model_edge();
        longint d, p;
        logic   exp_now;
        m_edge++;
        exp_now = 1'b0;
        if (csr_we && csr_num == 14'h41) begin
            m_tcfg = (m_tcfg & ~csr_wmask) | (csr_wvalue & csr_wmask);
            m_arm  = m_edge;
        end else if (m_tcfg[0]) begin
            d = m_edge - m_arm;
            p = m_init() + 1;
            exp_now = (d > 0) && (d % p == 0) && (m_tcfg[1] || d == p);
        end
        if (exp_now) m_ti = 1'b1;
        else if (csr_we && csr_num == 14'h44 && csr_wvalue[0] && csr_wmask[0]) m_ti = 1'b0;
        if (csr_we && csr_num == 14'h4)
            m_lie = ((m_lie & ~csr_wmask[12:0]) | (csr_wvalue[12:0] & csr_wmask[12:0])) & 13'h1BFF;
        if (csr_we && csr_num == 14'h5)
            m_swi = (m_swi & ~csr_wmask[1:0]) | (csr_wvalue[1:0] & csr_wmask[1:0]);
        hw_seen.push_back(hw_int_in);
        ipi_seen.push_back(ipi_int_in);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        csr_we = 1'b0;
    endtask

    task automatic csr_write(input logic [13:0] a, input logic [31:0] v, input logic [31:0] m);
        csr_num    = a;
        csr_wvalue = v;
        csr_wmask  = m;
        csr_we     = 1'b1;
        step();
    endtask

    task automatic rd_check(input string tag, input logic [13:0] a, input logic [31:0] exp);
        csr_num = a;
        #1;
        check(tag, intr_rvalue, exp);
    endtask

    task automatic check_all(input string tag);
        logic [13:0] addrs [6];
        addrs = '{14'h4, 14'h5, 14'h41, 14'h42, 14'h44, 14'h43};
        for (int i = 0; i < 6; i++) begin
            csr_num = addrs[i];
            #1;
            check($sformatf("%s rd_%0h", tag, addrs[i]), intr_rvalue, m_read(addrs[i]));
            check($sformatf("%s hit_%0h", tag, addrs[i]), 32'(intr_hit), 32'(m_hit(addrs[i])));
        end
        check({tag, " has_int"}, 32'(has_int), 32'(m_has_int()));
        check({tag, " timer_irq"}, 32'(timer_irq), 32'(m_is()[11]));
    endtask

    initial begin
        logic [13:0] raddrs [7];
        logic [13:0] a;
        logic [31:0] v;
        raddrs = '{14'h4, 14'h5, 14'h41, 14'h42, 14'h44, 14'h0, 14'h43};

        // Reset and idle state
        #3 resetn = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        resetn = 1'b1;
        step();
        step();
        check_all("post_reset");
        rd_check("post_reset tval", 14'h42, 32'h0);

        // One-shot timer, InitVal=2
        crmd_ie = 1'b1;
        csr_write(14'h4, 32'h800, 32'hFFFFFFFF);
        check_all("lie_800");
        csr_write(14'h41, 32'h9, 32'hFFFFFFFF);
        check_all("oneshot_w");
        rd_check("oneshot tval0", 14'h42, 32'h8);
        for (int i = 1; i <= 11; i++) begin
            step();
            check_all($sformatf("oneshot_%0d", i));
            if (i == 8) check("oneshot irq_early", 32'(timer_irq), 32'h0);
            if (i == 9) check("oneshot has_int", 32'(has_int), 32'h1);
        end
        rd_check("oneshot tval_hold", 14'h42, 32'h0);
        csr_write(14'h44, 32'h1, 32'hFFFFFFFF);
        check("ticlr has_int", 32'(has_int), 32'h0);
        check_all("ticlr");

        // Periodic timer, TICLR on an expiry cycle
        csr_write(14'h41, 32'hB, 32'hFFFFFFFF);
        for (int i = 1; i <= 8; i++) begin
            step();
            check_all($sformatf("periodic_%0d", i));
        end
        csr_write(14'h44, 32'h1, 32'h1);
        check("ticlr_vs_expiry", 32'(timer_irq), 32'h1);
        for (int i = 1; i <= 10; i++) begin
            step();
            check_all($sformatf("periodic2_%0d", i));
        end
        csr_write(14'h44, 32'h1, 32'h1);
        check("periodic ticlr", 32'(timer_irq), 32'h0);
        csr_write(14'h41, 32'h0, 32'hFFFFFFFF);
        check_all("timer_off");

        // Hardware line latency and global enable
        csr_write(14'h4, 32'h10, 32'hFFFFFFFF);
        hw_int_in = 8'h04;
        step();
        check("hw lat1", 32'(has_int), 32'h0);
        step();
        check("hw lat2", 32'(has_int), 32'h1);
        crmd_ie = 1'b0;
        #1;
        check("hw ie0", 32'(has_int), 32'h0);
        rd_check("hw estat", 14'h5, 32'h10);
        check_all("hw_ie0");
        hw_int_in = 8'h00;
        step();
        step();
        check_all("hw_clear");

        // ESTAT write affects only the software bits
        crmd_ie = 1'b1;
        csr_write(14'h5, 32'hFFFFFFFF, 32'hFFFFFFFF);
        rd_check("estat swi", 14'h5, 32'h3);
        csr_write(14'h4, 32'h1, 32'hFFFFFFFF);
        check("swi has_int", 32'(has_int), 32'h1);
        check_all("swi");
        csr_write(14'h42, 32'h1234, 32'hFFFFFFFF);
        check_all("tval_ro");
        csr_write(14'h5, 32'h0, 32'h3);
        check_all("swi_clear");

        // Reset while counting
        csr_write(14'h4, 32'h800, 32'hFFFFFFFF);
        csr_write(14'h41, 32'h9, 32'hFFFFFFFF);
        step();
        step();
        step();
        rd_check("mid tval5", 14'h42, 32'h5);
        resetn = 1'b0;
        model_reset();
        #1;
        check_all("mid_reset");
        rd_check("mid_reset tval", 14'h42, 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        crmd_ie = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            check_all($sformatf("after_reset_%0d", i));
        end
        check("after_reset irq", 32'(timer_irq), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7) == 0) hw_int_in = 8'($urandom);
            if ($urandom_range(7) == 0) ipi_int_in = 1'($urandom);
            if ($urandom_range(3) == 0) crmd_ie = 1'($urandom);
            if ($urandom_range(2) == 0) begin
                a = raddrs[$urandom_range(6)];
                v = $urandom;
                if (a == 14'h41) v = v & 32'h3F;
                csr_write(a, v, $urandom);
            end else begin
                step();
            end
            csr_num = raddrs[$urandom_range(6)];
            #1;
            check("rnd rd", intr_rvalue, m_read(csr_num));
            check("rnd hit", 32'(intr_hit), 32'(m_hit(csr_num)));
            check("rnd has_int", 32'(has_int), 32'(m_has_int()));
            check("rnd timer_irq", 32'(timer_irq), 32'(m_is()[11]));
            if (i % 50 == 0) check_all($sformatf("rnd_%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
